fp_minmax_reduce: RTL and testbench
===================================

// Module: fp_minmax_reduce
// PURPOSE
//  Sequences the single-precision fp_max datapath to reduce a stream of N operands
//  to one FMIN or FMAX result with accumulated exception flags.
//  Sits between a vector/loop issue stage and writeback: accepts a command, then
//  operands (valid/ready), then returns one result (valid/ready).
// PARAMETERS
//  MAX_LEN  256               largest legal operand count per reduction
//  LEN_W    $clog2(MAX_LEN+1) width of len / remaining counter
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  start      in   1      command strobe; accepted only while busy=0
//  op         in   1      0 = FMIN (rm=0), 1 = FMAX (rm=1)
//  len        in   LEN_W  operand count, 0..MAX_LEN; values >MAX_LEN clamp to MAX_LEN
//  busy       out  1      high from accepted start until result handshake
//  in_valid   in   1      operand valid
//  in_data    in   32     IEEE-754 single operand
//  in_ready   out  1      operand accepted when in_valid & in_ready
//  out_valid  out  1      result valid, held until out_ready
//  out_data   out  32     reduced result
//  out_flags  out  5      {NV,DZ,OF,UF,NX}; only NV (bit 4) can be set
//  out_ready  in   1      result consumer ready
//  out_index  out  LEN_W  [FP_REDUCE_INDEX_EN only] position of winning operand
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; busy, in_ready, out_valid = 0;
//    out_data = 32'h7FC00000, out_flags = 0, out_index = 0.
//  - FSM IDLE -> ACCUM on start (len>0); IDLE -> DONE on start with len=0.
//  - ACCUM -> DONE on the handshake of the last operand.
//  - DONE -> IDLE on out_valid & out_ready.
//  - Start accept latches op, remaining=len, acc=32'h7FC00000 (qNaN class), flags=0.
//  - ACCUM: in_ready=1. Each handshake: acc <= fp_max(acc, in_data).result;
//    flags <= flags | fp_max.flags; remaining--. Throughput 1 operand/cycle.
//    in_valid gaps stall without penalty.
//  - Latency: out_valid rises the cycle after the last operand handshake.
//    With len=0 it rises the cycle after start.
//  - NaN rules inherited from fp_max: qNaN acc seed is transparent.
//    sNaN operand raises NV and is dropped. All-NaN stream yields 7FC00000.
//    FMIN(+0,-0) = -0; FMAX(+0,-0) = +0.
//  - start while busy=1 is ignored (no effect, no error).
//  - start and final out_ready handshake in the same cycle: start is ignored;
//    the requester retries next cycle.
//  - DONE: out_data and out_flags stable while out_valid & !out_ready.
//  - Reset mid-ACCUM or mid-DONE discards the reduction immediately.
//  - Operand classify: exp==FF & mant!=0 -> NaN; mant[22]=0 -> sNaN (class[8]),
//    else qNaN (class[9]). ext = {data[31],1'b0,data[30:0]}.
// CONFIGURATION
//  FP_REDUCE_INDEX_EN defined:
//   - out_index port present; idx counter increments per handshake.
//   - out_index <= idx when the fp_max result bits differ from acc bits.
//   - Ties keep the earlier index; all-NaN stream gives 0.
//  FP_REDUCE_INDEX_EN undefined:
//   - out_index port and index logic absent; all other behaviour identical.
// STRUCTURE
//  - fp_wire package additions:
//    - fp_reduce_state_type enum {IDLE,ACCUM,DONE};
//    - constant FP_CANON_NAN = 32'h7FC00000;
//    - fp_reduce_reg_type: state, op, remaining, acc, flags, idx.
//  - Sub-module fp_max_class: 32-bit operand -> {ext[32:0], class[9:0]},
//    used for both the acc and in_data paths.
//  - Instantiates the existing fp_max unchanged.
//  - Two-process style: comb next-state, one registered always_ff.
// TESTING
//  1. FMAX, len=3, {3F800000,C0000000,40600000}
//     -> out_data=40600000, flags=00000, index=2.
//  2. FMIN, len=2, {7F800001,40000000}
//     -> out_data=40000000, flags=10000, index=1.
//  3. FMIN, len=2, {00000000,80000000} -> 80000000.
//     Same data with FMAX -> 00000000, index=0.
//  4. len=0 -> out_valid the cycle after start, out_data=7FC00000, flags=0.
//     len=2 all 7FC00001 -> 7FC00000, flags=0.
//  5. Backpressure on len=4 max:
//     - in_valid gaps of 2 cycles; out_ready low 3 cycles -> out_data/out_flags stable.
//     - start pulsed during ACCUM and DONE is ignored.
//  6. Reset low at operand 2 of 5 -> next cycle busy=0, out_valid=0.
//     New len=1 {BF800000} -> BF800000.

Source files
------------

// File: rtl/fp_minmax_reduce_pkg.sv
// Shared types and constants for the FMIN/FMAX stream reducer.
// FP_REDUCE_INDEX_EN adds the winning-operand index to the register record.
package fp_minmax_reduce_pkg;

  localparam int          FP_REDUCE_MAX_LEN = 256;
  localparam int          FP_REDUCE_LEN_W   = $clog2(FP_REDUCE_MAX_LEN + 1);
  localparam logic [31:0] FP_CANON_NAN      = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } fp_reduce_state_type;

  typedef struct packed {
    fp_reduce_state_type          state;
    logic                         op;
    logic [FP_REDUCE_LEN_W-1:0]   remaining;
    logic [31:0]                  acc;
    logic [4:0]                   flags;
`ifdef FP_REDUCE_INDEX_EN
    logic [FP_REDUCE_LEN_W-1:0]   idx;
`endif
  } fp_reduce_reg_type;

  // Idle record: the accumulator holds the canonical qNaN so the first
  // real operand passes straight through fp_max.
  function automatic fp_reduce_reg_type fp_reduce_reg_reset();
    fp_reduce_reg_type r;
    r       = '0;
    r.state = IDLE;
    r.acc   = FP_CANON_NAN;
    return r;
  endfunction

endpackage

// File: rtl/fp_max.sv
// IEEE-754-2019 minimumNumber/maximumNumber on classified operands:
// rm=0 selects FMIN, rm=1 FMAX; -0 orders below +0; sNaN raises NV.
module fp_max
  import fp_minmax_reduce_pkg::*;
(
  input  logic [32:0] data1,
  input  logic [32:0] data2,
  input  logic [9:0]  class1,
  input  logic [9:0]  class2,
  input  logic        rm,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  logic        nan1;
  logic        nan2;
  logic        snan;
  logic        a_lt_b;
  logic [31:0] val1;
  logic [31:0] val2;
  logic        class_unused;

  assign nan1 = class1[8] | class1[9];
  assign nan2 = class2[8] | class2[9];
  assign snan = class1[8] | class2[8];
  assign val1 = {data1[32], data1[30:0]};
  assign val2 = {data2[32], data2[30:0]};
  assign class_unused = ^{class1[7:0], class2[7:0]};

  // Sign-magnitude ordering; equal encodings give a_lt_b=0 so ties keep data1.
  always_comb begin
    if (data1[32] != data2[32]) begin
      a_lt_b = data1[32];
    end else if (data1[32]) begin
      a_lt_b = data1[31:0] > data2[31:0];
    end else begin
      a_lt_b = data1[31:0] < data2[31:0];
    end
  end

  always_comb begin
    if (nan1 && nan2) begin
      result = FP_CANON_NAN;
    end else if (nan1) begin
      result = val2;
    end else if (nan2) begin
      result = val1;
    end else if (rm) begin
      result = a_lt_b ? val2 : val1;
    end else begin
      result = a_lt_b ? val1 : val2;
    end
  end

  assign flags = {snan, 4'b0000};

endmodule

// File: rtl/fp_max_class.sv
// Single-precision operand classifier: 33-bit extended form plus the
// ten-bit fclass vector {qNaN,sNaN,+inf,+norm,+sub,+0,-0,-sub,-norm,-inf}.
module fp_max_class (
  input  logic [31:0] data,
  output logic [32:0] ext,
  output logic [9:0]  fclass
);

  logic       sign;
  logic       exp_max;
  logic       exp_zero;
  logic       mant_zero;
  logic       is_nan;
  logic       is_inf;
  logic       is_zero;
  logic       is_sub;
  logic       is_norm;

  assign ext       = {data[31], 1'b0, data[30:0]};
  assign sign      = data[31];
  assign exp_max   = &data[30:23];
  assign exp_zero  = ~|data[30:23];
  assign mant_zero = ~|data[22:0];

  assign is_nan  = exp_max & ~mant_zero;
  assign is_inf  = exp_max & mant_zero;
  assign is_zero = exp_zero & mant_zero;
  assign is_sub  = exp_zero & ~mant_zero;
  assign is_norm = ~exp_max & ~exp_zero;

  assign fclass[0] = sign & is_inf;
  assign fclass[1] = sign & is_norm;
  assign fclass[2] = sign & is_sub;
  assign fclass[3] = sign & is_zero;
  assign fclass[4] = ~sign & is_zero;
  assign fclass[5] = ~sign & is_sub;
  assign fclass[6] = ~sign & is_norm;
  assign fclass[7] = ~sign & is_inf;
  // The quiet bit (mantissa MSB) separates signalling from quiet NaNs.
  assign fclass[8] = is_nan & ~data[22];
  assign fclass[9] = is_nan & data[22];

endmodule

// File: rtl/fp_minmax_reduce.sv
// Reduces a stream of len single-precision operands to one FMIN/FMAX result.
// FP_REDUCE_INDEX_EN adds out_index, the position of the winning operand.
module fp_minmax_reduce
  import fp_minmax_reduce_pkg::*;
#(
  parameter int MAX_LEN = FP_REDUCE_MAX_LEN,
  parameter int LEN_W   = FP_REDUCE_LEN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [4:0]       out_flags,
  input  logic             out_ready
`ifdef FP_REDUCE_INDEX_EN
  ,
  output logic [LEN_W-1:0] out_index
`endif
);

  fp_reduce_reg_type r_q;
  fp_reduce_reg_type r_d;

  logic [LEN_W-1:0] len_clamped;
  logic [32:0]      acc_ext;
  logic [9:0]       acc_class;
  logic [32:0]      in_ext;
  logic [9:0]       in_class;
  logic [31:0]      max_res;
  logic [4:0]       max_flags;

`ifdef FP_REDUCE_INDEX_EN
  logic [LEN_W-1:0] out_index_q;
  logic [LEN_W-1:0] out_index_d;
`endif

  assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

  fp_max_class u_class_acc (
    .data   (r_q.acc),
    .ext    (acc_ext),
    .fclass (acc_class)
  );

  fp_max_class u_class_in (
    .data   (in_data),
    .ext    (in_ext),
    .fclass (in_class)
  );

  fp_max u_fp_max (
    .data1  (acc_ext),
    .data2  (in_ext),
    .class1 (acc_class),
    .class2 (in_class),
    .rm     (r_q.op),
    .result (max_res),
    .flags  (max_flags)
  );

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    r_d = r_q;
`ifdef FP_REDUCE_INDEX_EN
    out_index_d = out_index_q;
`endif
    unique case (r_q.state)
      IDLE: begin
        if (start) begin
          r_d           = fp_reduce_reg_reset();
          r_d.op        = op;
          r_d.remaining = FP_REDUCE_LEN_W'(len_clamped);
          r_d.state     = (len_clamped == '0) ? DONE : ACCUM;
`ifdef FP_REDUCE_INDEX_EN
          out_index_d   = '0;
`endif
        end
      end
      ACCUM: begin
        if (in_valid) begin
          r_d.acc       = max_res;
          r_d.flags     = r_q.flags | max_flags;
          r_d.remaining = r_q.remaining - FP_REDUCE_LEN_W'(1);
`ifdef FP_REDUCE_INDEX_EN
          r_d.idx = r_q.idx + FP_REDUCE_LEN_W'(1);
          // Only a strict change of the accumulator moves the index, so ties
          // and dropped NaNs keep the earlier winner.
          if (max_res != r_q.acc) begin
            out_index_d = LEN_W'(r_q.idx);
          end
`endif
          if (r_q.remaining == FP_REDUCE_LEN_W'(1)) begin
            r_d.state = DONE;
          end
        end
      end
      DONE: begin
        // A start coinciding with the result handshake is dropped here.
        if (out_ready) begin
          r_d.state = IDLE;
        end
      end
      default: r_d.state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= fp_reduce_reg_reset();
`ifdef FP_REDUCE_INDEX_EN
      out_index_q <= '0;
`endif
    end else begin
      r_q <= r_d;
`ifdef FP_REDUCE_INDEX_EN
      out_index_q <= out_index_d;
`endif
    end
  end

  assign busy      = (r_q.state != IDLE);
  assign in_ready  = (r_q.state == ACCUM);
  assign out_valid = (r_q.state == DONE);
  assign out_data  = r_q.acc;
  assign out_flags = r_q.flags;
`ifdef FP_REDUCE_INDEX_EN
  assign out_index = out_index_q;
`endif

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Directed bench for fp_minmax_reduce: vector table plus hand-written
// backpressure, reset-abort and length-clamp sequences.
module tb_fp_minmax_reduce;
  import fp_minmax_reduce_pkg::*;

  localparam int LW = FP_REDUCE_LEN_W;
  localparam int WAIT_LIMIT = 50;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [4:0]    out_flags;
  logic          out_ready = 1'b0;
`ifdef FP_REDUCE_INDEX_EN
  logic [LW-1:0] out_index;
`endif

  int checks = 0;
  int errors = 0;

  fp_minmax_reduce dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_ready (out_ready)
`ifdef FP_REDUCE_INDEX_EN
    ,
    .out_index (out_index)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    logic             op;
    int               len;
    logic [3:0][31:0] d;
    logic [31:0]      exp_d;
    logic [4:0]       exp_f;
    int               exp_idx;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic o, input int l,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [31:0] ed, input logic [4:0] ef,
                              input int ei);
    vec_t v;
    v.op = o; v.len = l; v.d = {d3, d2, d1, d0};
    v.exp_d = ed; v.exp_f = ef; v.exp_idx = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_start(input logic o, input logic [LW-1:0] l);
    start = 1'b1; op = o; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && n < WAIT_LIMIT) begin
      tick();
      n++;
    end
    if (n == WAIT_LIMIT) check("in_ready_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic collect(output logic [31:0] d, output logic [4:0] f, output int idx);
    int n = 0;
    while (!out_valid && n < WAIT_LIMIT) begin
      tick();
      n++;
    end
    if (n == WAIT_LIMIT) check("out_valid_wait", out_valid, 1);
    d = out_data; f = out_flags;
`ifdef FP_REDUCE_INDEX_EN
    idx = int'(out_index);
`else
    idx = 0;
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [31:0] got_d;
  logic [4:0]  got_f;
  int          got_i;

  initial begin
    vecs[0]  = mk(1'b1, 3, 32'h3F800000, 32'hC0000000, 32'h40600000, 32'h0, 32'h40600000, 5'h00, 2);
    vecs[1]  = mk(1'b0, 2, 32'h7F800001, 32'h40000000, 32'h0, 32'h0, 32'h40000000, 5'h10, 1);
    vecs[2]  = mk(1'b0, 2, 32'h00000000, 32'h80000000, 32'h0, 32'h0, 32'h80000000, 5'h00, 1);
    vecs[3]  = mk(1'b1, 2, 32'h00000000, 32'h80000000, 32'h0, 32'h0, 32'h00000000, 5'h00, 0);
    vecs[4]  = mk(1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7FC00000, 5'h00, 0);
    vecs[5]  = mk(1'b1, 2, 32'h7FC00001, 32'h7FC00001, 32'h0, 32'h0, 32'h7FC00000, 5'h00, 0);
    vecs[6]  = mk(1'b1, 3, 32'hC0000000, 32'hBF800000, 32'hC0400000, 32'h0, 32'hBF800000, 5'h00, 1);
    vecs[7]  = mk(1'b0, 3, 32'h7F800000, 32'hFF800000, 32'h00000000, 32'h0, 32'hFF800000, 5'h00, 1);
    vecs[8]  = mk(1'b1, 3, 32'h40000000, 32'hFF800001, 32'h3F800000, 32'h0, 32'h40000000, 5'h10, 0);
    vecs[9]  = mk(1'b0, 4, 32'h3F800000, 32'h00000001, 32'h80000001, 32'h7F800000, 32'h80000001, 5'h00, 2);
    vecs[10] = mk(1'b1, 2, 32'h40000000, 32'h40000000, 32'h0, 32'h0, 32'h40000000, 5'h00, 0);

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 32'h7FC00000);
    check("rst_out_flags", out_flags, 0);
`ifdef FP_REDUCE_INDEX_EN
    check("rst_out_index", out_index, 0);
`endif
    reset = 1'b1;
    tick();

    // Table-driven reductions with back-to-back operands
    for (int i = 0; i < NV; i++) begin
      send_start(vecs[i].op, LW'(vecs[i].len));
      for (int k = 0; k < vecs[i].len; k++) send_op(vecs[i].d[k]);
      check($sformatf("v%0d_latency", i), out_valid, 1);
      collect(got_d, got_f, got_i);
      check($sformatf("v%0d_data", i), got_d, vecs[i].exp_d);
      check($sformatf("v%0d_flags", i), got_f, vecs[i].exp_f);
`ifdef FP_REDUCE_INDEX_EN
      check($sformatf("v%0d_index", i), got_i, vecs[i].exp_idx);
`endif
      check($sformatf("v%0d_idle_after", i), busy, 0);
    end

    // Backpressure: input gaps, stray starts, held result
    send_start(1'b1, LW'(4));
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 2; g++) begin
        if (k == 1 && g == 0) begin
          start = 1'b1; op = 1'b0; len = LW'(1);
        end
        tick();
        start = 1'b0;
      end
      if (k == 3) check("bp_no_early_done", out_valid, 0);
      case (k)
        0: send_op(32'h3F800000);
        1: send_op(32'h40A00000);
        2: send_op(32'hC0400000);
        default: send_op(32'h40000000);
      endcase
    end
    check("bp_latency", out_valid, 1);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("bp_hold_valid%0d", c), out_valid, 1);
      check($sformatf("bp_hold_data%0d", c), out_data, 32'h40A00000);
      check($sformatf("bp_hold_flags%0d", c), out_flags, 0);
      check($sformatf("bp_hold_in_ready%0d", c), in_ready, 0);
    end
`ifdef FP_REDUCE_INDEX_EN
    check("bp_index", out_index, 1);
`endif
    out_ready = 1'b1; start = 1'b1; op = 1'b0; len = LW'(1);
    tick();
    out_ready = 1'b0; start = 1'b0;
    check("handshake_start_ignored_busy", busy, 0);
    check("handshake_start_ignored_valid", out_valid, 0);

    // Reset while the third of five operands is offered
    send_start(1'b1, LW'(5));
    send_op(32'h3F800000);
    send_op(32'h40000000);
    in_valid = 1'b1; in_data = 32'h40400000;
    reset = 1'b0;
    #1;
    check("abort_busy_async", busy, 0);
    check("abort_out_data", out_data, 32'h7FC00000);
    tick();
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    send_start(1'b0, LW'(1));
    send_op(32'hBF800000);
    collect(got_d, got_f, got_i);
    check("post_abort_data", got_d, 32'hBF800000);
    check("post_abort_flags", got_f, 0);
`ifdef FP_REDUCE_INDEX_EN
    check("post_abort_index", got_i, 0);
`endif

    // Oversize len clamps to 256 operands
    send_start(1'b1, LW'(300));
    for (int k = 0; k < 256; k++) begin
      if (k == 255) check("clamp_no_early_done", out_valid, 0);
      send_op(32'h3F800000 + 32'(k));
    end
    check("clamp_done", out_valid, 1);
    collect(got_d, got_f, got_i);
    check("clamp_data", got_d, 32'h3F8000FF);
`ifdef FP_REDUCE_INDEX_EN
    check("clamp_index", got_i, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
